// File: rtl/width_conv_pkg.sv
// Shared definitions for the 32-bit AXIS width conversion blocks
// (width_serializer on the transmit side, width_conv on the receive side).
package width_conv_pkg;

  // Width of one AXI-Stream beat on the narrow side.
  localparam int AXIS_DATA_WIDTH = 32;

  // Control state of a width converter.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } conv_state_e;

  // Number of narrow beats that make up one wide word.
  function automatic int beats_f(input int width);
    return width / AXIS_DATA_WIDTH;
  endfunction

endpackage

// File: rtl/width_serializer_if.sv
// Bundle of the parallel-word handshake and the 32-bit AXI-Stream output
// of the width serializer. The master modport is the serializer's view,
// the slave modport is the view of the logic around it.
interface width_serializer_if #(
  parameter int IN_WIDTH = 256
);
  import width_conv_pkg::*;

  logic [IN_WIDTH-1:0]        in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       m_axis_tlast;
  logic                       busy;

  modport master (
    input  in_data,
    input  in_valid,
    input  m_axis_tready,
    output in_ready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output busy
  );

  modport slave (
    output in_data,
    output in_valid,
    output m_axis_tready,
    input  in_ready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  busy
  );

endinterface

// File: rtl/width_serializer.sv
// Wide-to-narrow serializer: takes one IN_WIDTH word through a valid/ready
// handshake and replays it as a 32-bit AXI-Stream, least-significant beat
// first, with tlast on the final beat. A new word can be taken on the edge
// that transfers the last beat, so words stream back to back without a gap.
module width_serializer
  import width_conv_pkg::*;
#(
  parameter int IN_WIDTH = 256
) (
  input  logic               clk,
  input  logic               reset,
  width_serializer_if.master bus
);

  localparam int BEATS = beats_f(IN_WIDTH);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SEL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // Reject word widths that do not split evenly into 32-bit beats.
  if (((IN_WIDTH % AXIS_DATA_WIDTH) != 0) || (IN_WIDTH < AXIS_DATA_WIDTH)) begin : g_bad_width
    $fatal(1, "width_serializer: IN_WIDTH must be a non-zero multiple of 32");
  end

  conv_state_e          state_q;
  conv_state_e          state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [IN_WIDTH-1:0]  hold_q;
  logic [SEL_W-1:0]     beat_sel;

  logic tvalid_w;
  logic last_beat_w;
  logic beat_xfer_w;
  logic last_xfer_w;
  logic in_ready_w;
  logic accept_w;

  // Handshake terms; a word is only taken from IDLE or on the final-beat
  // transfer, so the held word is never overwritten mid-send.
  assign tvalid_w    = (state_q == SEND);
  assign last_beat_w = tvalid_w && (cnt_q == LAST_CNT);
  assign beat_xfer_w = tvalid_w && bus.m_axis_tready;
  assign last_xfer_w = beat_xfer_w && last_beat_w;
  assign in_ready_w  = !reset && ((state_q == IDLE) || last_xfer_w);
  assign accept_w    = bus.in_valid && in_ready_w;

  // Bit offset of the current beat inside the held word.
  assign beat_sel = SEL_W'(cnt_q) << $clog2(AXIS_DATA_WIDTH);

  assign bus.in_ready      = in_ready_w;
  assign bus.m_axis_tvalid = tvalid_w;
  assign bus.m_axis_tlast  = last_beat_w;
  assign bus.m_axis_tdata  = hold_q[beat_sel +: AXIS_DATA_WIDTH];
  assign bus.busy          = tvalid_w;

  // Next state: leave IDLE on accept, return only when the last beat goes
  // out with no follow-on word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_xfer_w && !accept_w) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding register captures the word on every accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (accept_w) begin
      hold_q <= bus.in_data;
    end
  end

  // Beat counter: restarts on a new word or after the last beat, otherwise
  // steps on each transfer; it never passes BEATS-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept_w || last_xfer_w) begin
      cnt_q <= '0;
    end else if (beat_xfer_w) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
